grid_scanner: RTL

GRID_SCANNER -- requirements
Module: grid_scanner

---
 rtl/grid_scanner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/grid_scanner.sv
// Row-multiplexed scanner for an 8x8 cell grid. It double-buffers incoming generations
// (pending -> display) and swaps them only on frame boundaries, so no frame ever tears.
module grid_scanner #(
    parameter int ROW_CYCLES   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] grid,
    input  logic        grid_valid,
    output logic        grid_ready,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        blank,
    output logic        frame_done
);

    localparam int CNT_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       row, row_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             boundary;

    logic [63:0]      display, display_nx;
    logic [63:0]      pending, pending_nx;
    logic             full, full_nx;

    logic             drive_nx;
    logic [7:0]       row_sel_nx;
    logic [7:0]       col_data_nx;
    logic             frame_done_nx;

    // Sequencing: boundary marks the edge that enters BLANK on row 0.
    always_comb begin
        state_nx = state;
        row_nx   = row;
        cnt_nx   = cnt;
        boundary = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = BLANK;
                    row_nx   = 3'd0;
                    cnt_nx   = '0;
                    boundary = 1'b1;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_nx = IDLE;
                    row_nx   = 3'd0;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST)
                        state_nx = DRIVE;
                end
            end
            DRIVE: begin
                if (!enable) begin
                    state_nx = IDLE;
                    row_nx   = 3'd0;
                    cnt_nx   = '0;
                end else if (cnt == ROW_LAST) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    row_nx   = row + 3'd1;
                    boundary = (row == 3'd7);
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                row_nx   = 3'd0;
                cnt_nx   = '0;
            end
        endcase
    end

    // Buffers: a boundary swap only happens when full, and capture only when not full,
    // so the two never fight over pending on the same edge.
    always_comb begin
        display_nx = display;
        pending_nx = pending;
        full_nx    = full;
        if (boundary && full) begin
            display_nx = pending;
            full_nx    = 1'b0;
        end
        if (grid_valid && grid_ready) begin
            pending_nx = grid;
            full_nx    = 1'b1;
        end
    end

    // Outputs are precomputed from next state and registered, so they come straight off flops.
    always_comb begin
        drive_nx      = (state_nx == DRIVE);
        row_sel_nx    = drive_nx ? (8'b1 << row_nx) : 8'h00;
        col_data_nx   = drive_nx ? display[8*row_nx +: 8] : 8'h00;
        frame_done_nx = drive_nx && (row_nx == 3'd7) && (cnt_nx == ROW_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            row        <= 3'd0;
            cnt        <= '0;
            display    <= '0;
            pending    <= '0;
            full       <= 1'b0;
            grid_ready <= 1'b1;
            row_sel    <= 8'h00;
            col_data   <= 8'h00;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            row        <= row_nx;
            cnt        <= cnt_nx;
            display    <= display_nx;
            pending    <= pending_nx;
            full       <= full_nx;
            grid_ready <= !full_nx;
            row_sel    <= row_sel_nx;
            col_data   <= col_data_nx;
            blank      <= !drive_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule
